// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared sizing helpers and requantisation for conv2d_stream
package conv_pkg;

    // Output dimension of a valid (unpadded) strided convolution
    function automatic int out_dim(input int img, input int k, input int stride);
        return (img - k) / stride + 1;
    endfunction

    // Full-precision width of one signed N x N product
    function automatic int prod_w(input int n);
        return 2 * n;
    endfunction

    // Width that holds the sum of all products without overflow
    function automatic int tree_w(input int n, input int terms);
        return 2 * n + $clog2(terms);
    endfunction

    // Round-half-up arithmetic shift, optional ReLU, then signed saturation to n bits
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                     input logic [4:0] shift,
                                                     input int n,
                                                     input logic relu);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r = acc;
        if (shift != 5'd0)
            r = (acc + (64'sd1 <<< (shift - 5'd1))) >>> shift;
        if (relu && (r < 64'sd0))
            r = 64'sd0;
        hi = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (n - 1));
        if (r > hi)
            r = hi;
        else if (r < lo)
            r = lo;
        return r;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - ROWS previous image rows, column-addressed, shifting down on write
module line_buffer #(
    parameter int W     = 8,
    parameter int DEPTH = 28,
    parameter int ROWS  = 2
) (
    input  logic                      clk,
    input  logic                      en,
    input  logic [$clog2(DEPTH)-1:0]  addr,
    input  logic [W-1:0]              din,
    output logic [ROWS*W-1:0]         taps
);

    logic [W-1:0] mem [ROWS][DEPTH];

    // Tap r is the pixel r+1 rows above the current one at the same column
    always_comb begin
        taps = '0;
        for (int r = 0; r < ROWS; r++)
            taps[r*W +: W] = mem[r][addr];
    end

    // On each accepted beat the column slot ages by one row
    always_ff @(posedge clk) begin
        if (en) begin
            mem[0][addr] <= din;
            for (int r = 1; r < ROWS; r++)
                mem[r][addr] <= mem[r-1][addr];
        end
    end

endmodule

// File: rtl/conv2d_stream.sv
// rtl/conv2d_stream.sv - streaming KxK convolution with stride, bias, shift, ReLU and saturation
module conv2d_stream
    import conv_pkg::*;
#(
    parameter int N      = 8,
    parameter int CH_IN  = 1,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 3,
    parameter int STRIDE = 1,
    parameter int ACC_W  = 32,
    parameter int RELU   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [CH_IN*N-1:0]        s_data,
    input  logic [CH_IN*K*K*N-1:0]    weight,
    input  logic [ACC_W-1:0]          bias,
    input  logic [4:0]                shift,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [N-1:0]              m_data,
    output logic                      m_last,
    output logic                      busy
);

    localparam int OUT_W    = out_dim(IMG_W, K, STRIDE);
    localparam int OUT_H    = out_dim(IMG_H, K, STRIDE);
    localparam int NT       = CH_IN * K * K;
    localparam int DW       = CH_IN * N;
    localparam int PW       = prod_w(N);
    localparam int TW       = tree_w(N, NT);
    localparam int CW       = $clog2(IMG_W);
    localparam int RW       = $clog2(IMG_H);
    localparam int LAST_COL = K - 1 + (OUT_W - 1) * STRIDE;
    localparam int LAST_ROW = K - 1 + (OUT_H - 1) * STRIDE;

    logic [CW-1:0]              col;
    logic [RW-1:0]              row;
    logic                       stall, en, accept, first, win_ok, win_last;
    logic [(K-1)*DW-1:0]        taps;
    logic [DW-1:0]              win [K][K];
    logic [NT*N-1:0]            weight_r;
    logic signed [ACC_W-1:0]    bias_r, bias2, acc3, acc_next;
    logic [4:0]                 shift_r, shift2, shift3;
    logic                       busy_r;
    logic                       v1, v2, v3, last1, last2, last3;
    logic signed [PW-1:0]       prod [NT];
    logic signed [TW-1:0]       tree;
    logic signed [N-1:0]        res;

    assign stall  = m_valid && !m_ready;
    assign en     = !stall;
    assign s_ready = !stall;
    assign accept = s_valid && s_ready;
    assign first  = (col == '0) && (row == '0);
    assign busy   = busy_r;

    // Window position test for the beat currently on the input
    always_comb begin
        int ci, ri;
        ci = int'(col);
        ri = int'(row);
        win_ok   = (ri >= K - 1) && (ci >= K - 1) &&
                   (((ri - K + 1) % STRIDE) == 0) && (((ci - K + 1) % STRIDE) == 0);
        win_last = (ri == LAST_ROW) && (ci == LAST_COL);
    end

    line_buffer #(.W(DW), .DEPTH(IMG_W), .ROWS(K - 1)) u_line_buffer (
        .clk  (clk),
        .en   (accept),
        .addr (col),
        .din  (s_data),
        .taps (taps)
    );

    // Raster counters, per-frame parameter capture and frame-busy flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col      <= '0;
            row      <= '0;
            weight_r <= '0;
            bias_r   <= '0;
            shift_r  <= '0;
            busy_r   <= 1'b0;
        end else begin
            if (accept) begin
                if (col == CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                if (first) begin
                    weight_r <= weight;
                    bias_r   <= bias;
                    shift_r  <= shift;
                end
            end
            if (accept && first)
                busy_r <= 1'b1;
            else if (m_valid && m_ready && m_last)
                busy_r <= 1'b0;
        end
    end

    // S1: shift the KxK window left, newest column enters from line buffer taps
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int ky = 0; ky < K; ky++) begin
                for (int kx = 0; kx < K - 1; kx++)
                    win[ky][kx] <= win[ky][kx+1];
                win[ky][K-1] <= (ky == K - 1) ? s_data : taps[(K-2-ky)*DW +: DW];
            end
        end
    end

    // S2: signed products; bias/shift travel with the data so a new frame cannot disturb them
    always_ff @(posedge clk) begin
        if (en) begin
            for (int c = 0; c < CH_IN; c++)
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++)
                        prod[c*K*K + ky*K + kx] <=
                            PW'($signed(win[ky][kx][c*N +: N])) *
                            PW'($signed(weight_r[(c*K*K + ky*K + kx)*N +: N]));
            bias2  <= bias_r;
            shift2 <= shift_r;
        end
    end

    // S3 combinational part: adder tree, then bias at accumulator width
    always_comb begin
        tree = '0;
        for (int i = 0; i < NT; i++)
            tree = tree + TW'(prod[i]);
        acc_next = ACC_W'(tree) + bias2;
    end

    // S3: accumulator register
    always_ff @(posedge clk) begin
        if (en) begin
            acc3   <= acc_next;
            shift3 <= shift2;
        end
    end

    // S4 combinational part: round, ReLU, saturate
    always_comb begin
        res = N'(round_sat(64'(acc3), shift3, N, RELU != 0));
    end

    // Valid/last pipeline and output register; everything freezes while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            last1   <= 1'b0;
            last2   <= 1'b0;
            last3   <= 1'b0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= '0;
        end else if (en) begin
            v1      <= accept && win_ok;
            last1   <= accept && win_last;
            v2      <= v1;
            last2   <= last1;
            v3      <= v2;
            last3   <= last2;
            m_valid <= v3;
            m_last  <= v3 && last3;
            if (v3)
                m_data <= res;
        end
    end

endmodule

// File: tb/tb_conv2d_stream.sv
// tb/tb_conv2d_stream.sv - table-driven scoreboard bench for conv2d_stream
module tb_conv2d_stream;

    typedef struct {
        int sel;
        int pmode;
        int p0;
        int p1;
        int wmode;
        int wv;
        int b;
        int sh;
        int e0;
        int e1;
        int e2;
        int e3;
    } vec_t;

    typedef struct {
        int d;
        int l;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         sel;
    logic         s_valid;
    logic [15:0]  s_data;
    logic [143:0] weight;
    logic [31:0]  bias;
    logic [4:0]   shift;
    logic         m_ready;

    logic       s_ready0, m_valid0, m_last0, busy0;
    logic [7:0] m_data0;
    logic       s_ready1, m_valid1, m_last1, busy1;
    logic [7:0] m_data1;
    logic       sr, mv, ml, bz;
    logic [7:0] md;

    int fpix [2][6][6];
    int fw [2][9];
    int fb, fsh, nch, img, strd, rl;
    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int n_stall = 0;
    int pstall = 0;
    int pd = 0;
    int pl = 0;
    vec_t vt [11];

    always #5 clk = ~clk;

    conv2d_stream #(.N(8), .CH_IN(2), .IMG_W(4), .IMG_H(4), .K(3), .STRIDE(1),
                    .ACC_W(32), .RELU(1)) dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid && !sel), .s_ready(s_ready0),
        .s_data(s_data), .weight(weight), .bias(bias), .shift(shift),
        .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0), .m_last(m_last0),
        .busy(busy0));

    conv2d_stream #(.N(8), .CH_IN(1), .IMG_W(6), .IMG_H(6), .K(3), .STRIDE(2),
                    .ACC_W(32), .RELU(0)) dut1 (
        .clk(clk), .rst(rst), .s_valid(s_valid && sel), .s_ready(s_ready1),
        .s_data(s_data[7:0]), .weight(weight[71:0]), .bias(bias), .shift(shift),
        .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .m_last(m_last1),
        .busy(busy1));

    assign sr = sel ? s_ready1 : s_ready0;
    assign mv = sel ? m_valid1 : m_valid0;
    assign ml = sel ? m_last1  : m_last0;
    assign md = sel ? m_data1  : m_data0;
    assign bz = sel ? busy1    : busy0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int model(input int y0, input int x0);
        longint s, r;
        s = 0;
        for (int c = 0; c < nch; c++)
            for (int ky = 0; ky < 3; ky++)
                for (int kx = 0; kx < 3; kx++)
                    s += longint'(fpix[c][y0+ky][x0+kx]) * longint'(fw[c][ky*3+kx]);
        r = s + longint'(fb);
        if (fsh > 0)
            r = (r + (longint'(1) << (fsh - 1))) >>> fsh;
        if (rl != 0 && r < 0) r = 0;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return int'(r);
    endfunction

    // Scoreboard: pop on each output transfer, and watch stall behaviour
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pstall = 0;
        end else begin
            if (pstall != 0) begin
                check("stall_hold_valid", int'(mv), 1);
                check("stall_hold_data", int'(md), pd);
                check("stall_hold_last", int'(ml), pl);
            end
            if (mv && !m_ready) begin
                n_stall++;
                check("stall_s_ready", int'(sr), 0);
            end
            if (mv && m_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got %0d, expected no output", int'($signed(md)));
                end else begin
                    e = q.pop_front();
                    check("data", int'($signed(md)), e.d);
                    check("last", int'(ml), e.l);
                end
            end
            pstall = (mv && !m_ready) ? 1 : 0;
            pd = int'(md);
            pl = int'(ml);
        end
    end

    task automatic load(input vec_t v);
        sel  = (v.sel != 0);
        img  = v.sel != 0 ? 6 : 4;
        nch  = v.sel != 0 ? 1 : 2;
        strd = v.sel != 0 ? 2 : 1;
        rl   = v.sel != 0 ? 0 : 1;
        for (int c = 0; c < 2; c++)
            for (int y = 0; y < 6; y++)
                for (int x = 0; x < 6; x++)
                    case (v.pmode)
                        0: fpix[c][y][x] = (c == 0) ? v.p0 : v.p1;
                        1: fpix[c][y][x] = (c == 0) ? y * img + x : 0;
                        default: fpix[c][y][x] = int'($urandom_range(0, 6)) - 3;
                    endcase
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 9; i++)
                case (v.wmode)
                    0: fw[c][i] = v.wv;
                    1: fw[c][i] = (i == 4) ? v.wv : 0;
                    default: fw[c][i] = int'($urandom_range(0, 6)) - 3;
                endcase
        fb  = v.b;
        fsh = v.sh;
    endtask

    // Drive up to nb beats of the loaded frame; expectations come from e[] or the model
    task automatic run_frame(input int use_tab, input int e [4], input int gap_pct, input int nb);
        int k, t, beats;
        exp_t ex;
        k = 0;
        beats = 0;
        for (int y = 0; y < img; y++) begin
            for (int x = 0; x < img; x++) begin
                if (beats < nb) begin
                    s_data = {8'(fpix[1][y][x]), 8'(fpix[0][y][x])};
                    if (y == 0 && x == 0) begin
                        weight = '0;
                        for (int c = 0; c < nch; c++)
                            for (int i = 0; i < 9; i++)
                                weight[(c*9+i)*8 +: 8] = 8'(fw[c][i]);
                        bias  = 32'(fb);
                        shift = 5'(fsh);
                    end else if (y == 0 && x == 1) begin
                        weight = 144'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
                        bias   = $urandom();
                        shift  = 5'($urandom());
                    end
                    while (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
                        s_valid = 1'b0;
                        @(posedge clk); #3;
                    end
                    s_valid = 1'b1;
                    t = 0;
                    while (!sr && t < 500) begin
                        @(posedge clk); #3;
                        t++;
                    end
                    if (t >= 500) check("s_ready_timeout", 0, 1);
                    if (y >= 2 && x >= 2 && (y - 2) % strd == 0 && (x - 2) % strd == 0) begin
                        ex.d = (use_tab != 0) ? e[k] : model(y - 2, x - 2);
                        ex.l = (k == 3) ? 1 : 0;
                        q.push_back(ex);
                        k++;
                    end
                    @(posedge clk); #3;
                    beats++;
                end
            end
        end
        s_valid = 1'b0;
        if (nb >= img * img) begin
            t = 0;
            while (q.size() > 0 && t < 500) begin
                @(posedge clk); #3;
                t++;
            end
            check("drain_queue_empty", q.size(), 0);
            @(posedge clk); #3;
            check("busy_after_frame", int'(bz), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        int e [4];
        vec_t rv;
        vt[0]  = '{0, 0, 1,   0, 0, 1,   0,   0, 9,   9,   9,   9};
        vt[1]  = '{0, 0, 127, 0, 0, 127, 0,   0, 127, 127, 127, 127};
        vt[2]  = '{0, 0, 1,   0, 0, -1,  0,   0, 0,   0,   0,   0};
        vt[3]  = '{0, 0, 1,   0, 0, 1,   0,   1, 5,   5,   5,   5};
        vt[4]  = '{0, 0, 1,   0, 0, 1,   100, 2, 27,  27,  27,  27};
        vt[5]  = '{0, 0, 1,   2, 0, 1,   0,   0, 27,  27,  27,  27};
        vt[6]  = '{1, 1, 0,   0, 1, 1,   0,   0, 7,   9,   19,  21};
        vt[7]  = '{1, 0, 1,   0, 0, -1,  0,   0, -9,  -9,  -9,  -9};
        vt[8]  = '{1, 0, 1,   0, 0, -1,  0,   1, -4,  -4,  -4,  -4};
        vt[9]  = '{1, 1, 0,   0, 1, 10,  0,   0, 70,  90,  127, 127};
        vt[10] = '{1, 1, 0,   0, 1, -10, 0,   0, -70, -90, -128, -128};

        rst = 1'b1; sel = 1'b0; s_valid = 1'b0; s_data = '0;
        weight = '0; bias = '0; shift = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk); #3;

        check("rst_s_ready0", int'(s_ready0), 1);
        check("rst_m_valid0", int'(m_valid0), 0);
        check("rst_m_data0",  int'(m_data0), 0);
        check("rst_m_last0",  int'(m_last0), 0);
        check("rst_busy0",    int'(busy0), 0);
        check("rst_s_ready1", int'(s_ready1), 1);
        check("rst_m_valid1", int'(m_valid1), 0);
        check("rst_m_data1",  int'(m_data1), 0);
        check("rst_m_last1",  int'(m_last1), 0);
        check("rst_busy1",    int'(busy1), 0);

        for (int i = 0; i < 11; i++) begin
            load(vt[i]);
            e[0] = vt[i].e0; e[1] = vt[i].e1; e[2] = vt[i].e2; e[3] = vt[i].e3;
            run_frame(1, e, 0, 999);
        end

        rv = '{0, 2, 0, 0, 2, 0, 5, 1, 0, 0, 0, 0};
        load(rv);
        n_stall = 0;
        fork
            begin
                repeat (12) @(posedge clk);
                #1;
                m_ready = 1'b0;
                repeat (10) @(posedge clk);
                #1;
                m_ready = 1'b1;
            end
            run_frame(0, e, 0, 999);
        join
        check("stall_cycles_seen", (n_stall >= 5) ? 1 : 0, 1);

        rv = '{0, 2, 0, 0, 2, 0, -3, 0, 0, 0, 0, 0};
        load(rv);
        run_frame(0, e, 20, 999);

        load(rv);
        run_frame(0, e, 0, 7);
        check("busy_mid_frame", int'(busy0), 1);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk); #3;
        check("mid_rst_m_valid", int'(m_valid0), 0);
        check("mid_rst_busy", int'(busy0), 0);
        check("mid_rst_s_ready", int'(s_ready0), 1);
        rst = 1'b0;
        @(posedge clk); #3;
        run_frame(0, e, 0, 999);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv2d_stream.md
# conv2d_stream

Streaming, fully parametrised 2-D convolution engine. Accepts a raster-scan pixel stream carrying `CH_IN` packed channels and produces one requantised output feature value per valid kernel window. It supports stride, per-frame bias and shift, optional ReLU and signed saturation, with valid/ready backpressure on both sides. It sits between the input feature stream and the pooling / next-layer blocks of the CNN datapath, one instance per output channel.

## Interface
- `N`, 8: signed data and weight width (two's complement).
- `CH_IN`, 1: input channels per pixel beat.
- `IMG_W`, 28: input image width in pixels.
- `IMG_H`, 28: input image height in pixels.
- `K`, 3: kernel size (K×K).
- `STRIDE`, 1: window stride, applied to rows and columns.
- `ACC_W`, 32: accumulator width.
- `RELU`, 1: 1 clamps negative results to 0.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `s_valid` in 1: input pixel beat valid.
- `s_ready` out 1: block accepts the beat.
- `s_data` in CH_IN*N: channel c at bits `[c*N +: N]`.
- `weight` in CH_IN*K*K*N: index `(c*K*K + ky*K + kx)`, each N bits.
- `bias` in ACC_W: signed bias.
- `shift` in 5: arithmetic right shift, 0..31.
- `m_valid` out 1: output valid.
- `m_ready` in 1: downstream accepts the output.
- `m_data` out N: signed result.
- `m_last` out 1: marks the final output of the frame.
- `busy` out 1: a frame is in progress or results are still in the pipeline.

## Operation
- An input beat transfers on `s_valid && s_ready`. Beats advance `col` (0..IMG_W-1), then `row` (0..IMG_H-1). Both counters wrap to 0 after the last pixel, and the next frame may follow immediately.
- `weight`, `bias` and `shift` are latched on the first beat of each frame (col=row=0). Changes mid-frame have no effect.
- Line buffer: K-1 rows × IMG_W words of CH_IN*N bits. A K×K×CH_IN window register shifts on every accepted beat.
- An output is produced when all of these hold:
  - `row ≥ K-1`
  - `col ≥ K-1`
  - `(row-K+1) % STRIDE == 0`
  - `(col-K+1) % STRIDE == 0`
- Outputs per frame: OUT_W×OUT_H, where OUT_W = (IMG_W-K)/STRIDE+1 and OUT_H = (IMG_H-K)/STRIDE+1.
- Arithmetic, in order:
  - sum = Σ signed products over CH_IN*K*K, sign-extended to ACC_W.
  - acc = sum + bias (wraps at ACC_W).
  - If shift>0, r = (acc + 2^(shift-1)) >>> shift; otherwise r = acc.
  - If RELU and r<0, r = 0.
  - Saturate r to [-2^(N-1), 2^(N-1)-1].
- `m_last` is asserted with output number OUT_W×OUT_H-1 of the frame.
- Pipeline stages: S1 window capture / valid-window flag, S2 products, S3 adder tree + bias, S4 round/ReLU/saturate into the output register.

## Timing
- Reset values: `s_ready`=1, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0. Counters, line buffer valid state and the pipeline valid bits all clear.
- Latency: 4 cycles from acceptance of the window-completing beat to `m_valid`, with no stall.
- Stall = `m_valid && !m_ready`.
  - During a stall the whole pipeline freezes, `s_ready`=0, and `m_data`/`m_last` hold stable.
- Throughput: 1 beat/cycle when `m_ready` is held at 1.
- Bubbles (`s_valid`=0) propagate as cleared valid bits and never produce outputs.
- Reset mid-frame: the partial frame is discarded and no stale output appears. The next accepted beat is pixel (0,0).
- `busy` = 1 from the first beat of a frame until the `m_last` transfer.

## Structure
- Shared package `conv_pkg`:
  - OUT_W / OUT_H functions.
  - The saturate/round function.
  - The product width constant (2N) and adder-tree stage width.
- Sub-module `line_buffer`: parametrised width/depth, K-1 rows, with a shift-enable input. This sub-module replaces the old shift-register chain.

## Test plan
- IMG 4×4, K=3, S=1, CH_IN=1; all pixels 1, weights 1, bias 0, shift 0 → 4 outputs, each 9; `m_last` on the 4th only.
- IMG 6×6, K=3, S=2; pixel = raster index (0..35), centre weight 1, others 0 → outputs 7, 9, 19, 21. Out-of-range values saturate at 127.
- Pixels 127, weights 127, shift 0 → 127 (positive saturation). Weights -1, pixels 1: RELU=1 → 0; RELU=0 → -9.
- Rounding with shift=1: sum 9 → 5; sum -9 → -4. Bias 100, shift 2, sum 9 → 27.
- CH_IN=2, 4×4; ch0 = 1, ch1 = 2, all weights 1 → each output 27.
- Backpressure: `m_ready` low for 10 cycles mid-frame → `m_valid` held with stable `m_data`, `s_ready`=0, no loss or duplication against the golden model. Then assert `rst` after 7 beats, send a fresh frame → results identical to a clean run.
